// File: rtl/gf180_sram64x8_ctrl.sv
// Host-side controller for the gf180mcu 64x8 single-port SRAM macro.
// Requests are accepted on posedge, pins launch from negedge registers, read data returns through a 2-entry buffer.
module gf180_sram64x8_ctrl #(
    parameter int AW            = 6,
    parameter int DW            = 8,
    parameter int INIT_CYCLES   = 2,
    parameter int CLEAR_ON_INIT = 1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    input  logic [DW-1:0] req_wmask,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          init_done,
    output logic          sram_cen,
    output logic          sram_gwen,
    output logic [DW-1:0] sram_wen,
    output logic [AW-1:0] sram_a,
    output logic [DW-1:0] sram_d,
    input  logic [DW-1:0] sram_q
);

    localparam int DEPTH = 1 << AW;
    localparam int ICW   = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

    localparam logic [1:0] ST_CEN_HI = 2'd0;
    localparam logic [1:0] ST_CLEAR  = 2'd1;
    localparam logic [1:0] ST_RUN    = 2'd2;

    // Handshake: a request transfers on the CLK posedge where req_valid && req_ready;
    // a response transfers on the posedge where rsp_valid && rsp_ready. Neither ready
    // depends combinationally on the matching valid.

    logic [1:0]     state;
    logic [ICW-1:0] init_cnt;
    logic [AW-1:0]  clr_cnt;

    logic           iss_valid;
    logic           iss_write;
    logic [AW-1:0]  iss_addr;
    logic [DW-1:0]  iss_data;
    logic [DW-1:0]  iss_mask;

    logic           rd_pipe1;
    logic           rd_pipe2;

    logic [DW-1:0]  fifo_mem [2];
    logic           wr_ptr;
    logic           rd_ptr;
    logic [1:0]     fifo_count;

    logic           accept;
    logic           push;
    logic           pop;
    logic [2:0]     occupancy;

    // Reads in flight reserve buffer space, so the sum never exceeds the two slots.
    assign occupancy = {1'b0, fifo_count} + {2'b00, rd_pipe1} + {2'b00, rd_pipe2};
    assign req_ready = (state == ST_RUN) && (occupancy < 3'd2);
    assign accept    = req_valid && req_ready;
    assign push      = rd_pipe2;
    assign pop       = rsp_valid && rsp_ready;
    assign rsp_valid = (fifo_count != 2'd0);
    assign rsp_rdata = fifo_mem[rd_ptr];
    assign init_done = (state == ST_RUN);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= ST_CEN_HI;
            init_cnt <= '0;
            clr_cnt  <= '0;
        end else begin
            case (state)
                ST_CEN_HI: begin
                    if (init_cnt == ICW'(INIT_CYCLES - 1)) begin
                        init_cnt <= '0;
                        state    <= (CLEAR_ON_INIT != 0) ? ST_CLEAR : ST_RUN;
                    end else begin
                        init_cnt <= init_cnt + 1'b1;
                    end
                end
                ST_CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == AW'(DEPTH - 1)) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    state <= ST_RUN;
                end
                default: begin
                    state <= ST_CEN_HI;
                end
            endcase
        end
    end

    // Issue register: what the pins should show from the following negedge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            iss_valid <= 1'b0;
            iss_write <= 1'b0;
            iss_addr  <= '0;
            iss_data  <= '0;
            iss_mask  <= '0;
        end else begin
            iss_valid <= 1'b0;
            iss_write <= 1'b0;
            if (state == ST_CLEAR) begin
                iss_valid <= 1'b1;
                iss_write <= 1'b1;
                iss_addr  <= clr_cnt;
                iss_data  <= '0;
                iss_mask  <= '1;
            end else if (accept && !(req_write && (req_wmask == '0))) begin
                iss_valid <= 1'b1;
                iss_write <= req_write;
                iss_addr  <= req_addr;
                if (req_write) begin
                    iss_data <= req_wdata;
                    iss_mask <= req_wmask;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_pipe1 <= 1'b0;
            rd_pipe2 <= 1'b0;
        end else begin
            rd_pipe1 <= accept && !req_write;
            rd_pipe2 <= rd_pipe1;
        end
    end

    // Q is valid after the macro edge that executed the read; it is captured one posedge later.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            fifo_count <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= sram_q;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Falling-edge launch gives the macro half a cycle of setup and hold around its posedge.
    always_ff @(negedge CLK) begin
        if (RST) begin
            sram_cen  <= 1'b1;
            sram_gwen <= 1'b1;
            sram_wen  <= '1;
            sram_a    <= '0;
            sram_d    <= '0;
        end else begin
            sram_cen  <= ~iss_valid;
            sram_gwen <= ~(iss_valid && iss_write);
            sram_wen  <= (iss_valid && iss_write) ? ~iss_mask : '1;
            sram_a    <= iss_addr;
            sram_d    <= iss_data;
        end
    end

endmodule

// File: tb/tb_gf180_sram64x8_ctrl.sv
// Bench for gf180_sram64x8_ctrl: behavioural macro model, table vectors, hand sequences and random traffic.
module tb_gf180_sram64x8_ctrl;

    localparam int AW          = 6;
    localparam int DW          = 8;
    localparam int DEPTH       = 64;
    localparam int INIT_CYCLES = 2;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [DW-1:0] req_wmask = '0;
    logic          rsp_ready = 1'b1;
    logic          req_ready;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          init_done;
    logic          sram_cen;
    logic          sram_gwen;
    logic [DW-1:0] sram_wen;
    logic [AW-1:0] sram_a;
    logic [DW-1:0] sram_d;
    logic [DW-1:0] sram_q;

    // ---------------- clock / reset ----------------
    always #5 CLK = ~CLK;

    gf180_sram64x8_ctrl #(
        .AW(AW), .DW(DW), .INIT_CYCLES(INIT_CYCLES), .CLEAR_ON_INIT(1)
    ) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .init_done(init_done),
        .sram_cen(sram_cen), .sram_gwen(sram_gwen), .sram_wen(sram_wen),
        .sram_a(sram_a), .sram_d(sram_d), .sram_q(sram_q)
    );

    // ---------------- SRAM macro model (garbage at power-up) ----------------
    logic [DW-1:0] mac_mem [DEPTH];
    logic [DW-1:0] mac_q = '0;
    logic          mac_seeded = 1'b0;
    assign sram_q = mac_q;

    always @(posedge CLK) begin
        if (!mac_seeded) begin
            for (int i = 0; i < DEPTH; i++) mac_mem[i] <= 8'($urandom);
            mac_seeded <= 1'b1;
        end else if (!sram_cen) begin
            if (!sram_gwen) mac_mem[sram_a] <= (mac_mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
            else            mac_q <= mac_mem[sram_a];
        end
    end

    // ---------------- counters, reference model, scoreboard ----------------
    int n_vec  = 0;
    int n_fail = 0;
    int cyc    = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] exp_q [$];

    typedef struct {
        int            cyc;
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] wmask;
    } pin_t;
    pin_t pin_q [$];

    typedef struct {
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] wmask;
        logic [DW-1:0] exp_rd;
    } vec_t;
    vec_t tbl [14];

    logic          pin_en  = 1'b0;
    logic          a_known = 1'b0;
    logic          d_known = 1'b0;
    logic [AW-1:0] last_a  = '0;
    logic [DW-1:0] last_d  = '0;
    logic          bp_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- driver ----------------
    task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [DW-1:0] m, input logic use_exp, input logic [DW-1:0] exp_rd);
        int   waited = 0;
        bit   acc = 0;
        pin_t p;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_wmask = m;
        while (!acc && waited < 60) begin
            if (req_ready) acc = 1;
            @(posedge CLK); #1;
            waited++;
        end
        req_valid = 1'b0;
        if (!acc) begin
            n_vec++;
            n_fail++;
            $display("FAIL req_timeout: got no accept in 60 cycles, expected accept (addr 0x%0h)", a);
        end else begin
            if (w) ref_mem[a] = (ref_mem[a] & ~m) | (d & m);
            else   exp_q.push_back(use_exp ? exp_rd : ref_mem[a]);
            p.cyc = cyc; p.write = w; p.addr = a; p.wdata = d; p.wmask = m;
            pin_q.push_back(p);
        end
    endtask

    task automatic drain();
        int w = 0;
        rsp_ready = 1'b1;
        while (exp_q.size() != 0 && w < 100) begin
            @(posedge CLK); #1;
            w++;
        end
        chk("drain_pending", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic init_seq();
        @(posedge CLK);
        for (int i = 0; i < INIT_CYCLES; i++) begin
            @(negedge CLK); #1;
            chk("init_cen_hi", 32'(sram_cen), 32'd1);
        end
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge CLK); #1;
            chk("clear_write", 32'({sram_cen, sram_gwen, sram_wen, sram_a, sram_d}),
                32'({1'b0, 1'b0, 8'h00, AW'(i), 8'h00}));
            if (i == DEPTH - 2) chk("init_done_early", 32'(init_done), 32'd0);
        end
        @(negedge CLK); #1;
        chk("init_done_ready", 32'({init_done, req_ready, sram_cen}), 32'b111);
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        exp_q.delete();
        pin_q.delete();
        @(posedge CLK); #1;
    endtask

    // ---------------- pin monitor ----------------
    always begin
        pin_t p;
        @(negedge CLK); #1;
        if (pin_en) begin
            if (pin_q.size() > 0 && pin_q[0].cyc == cyc) begin
                p = pin_q.pop_front();
                if (p.write && p.wmask == '0) begin
                    chk("pin_nomask_idle", 32'(sram_cen), 32'd1);
                    a_known = 1'b0;
                    d_known = 1'b0;
                end else if (p.write) begin
                    chk("pin_write", 32'({sram_cen, sram_gwen, sram_wen, sram_a, sram_d}),
                        32'({1'b0, 1'b0, ~p.wmask, p.addr, p.wdata}));
                    last_a = p.addr; last_d = p.wdata;
                    a_known = 1'b1;  d_known = 1'b1;
                end else begin
                    chk("pin_read", 32'({sram_cen, sram_gwen, sram_wen, sram_a}),
                        32'({1'b0, 1'b1, 8'hFF, p.addr}));
                    last_a = p.addr;
                    a_known = 1'b1;
                end
            end else begin
                chk("pin_idle", 32'({sram_cen, sram_gwen, sram_wen}), 32'({1'b1, 1'b1, 8'hFF}));
                if (a_known) chk("pin_hold_a", 32'(sram_a), 32'(last_a));
                if (d_known) chk("pin_hold_d", 32'(sram_d), 32'(last_d));
            end
        end
    end

    // ---------------- response scoreboard ----------------
    always begin
        logic [DW-1:0] e;
        @(negedge CLK); #1;
        if (!RST && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL rsp_unexpected: got 0x%0h, expected no response", rsp_rdata);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_data", 32'(rsp_rdata), 32'(e));
            end
        end
    end

    // Random consumer back-pressure.
    always begin
        @(posedge CLK); #1;
        if (bp_en) rsp_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish by 400000, expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- test sequence ----------------
    initial begin
        bit            found;
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] m;

        tbl[0]  = '{1'b1, 6'd5,  8'hFF, 8'h0F, 8'h00};
        tbl[1]  = '{1'b0, 6'd5,  8'h00, 8'h00, 8'hAF};
        tbl[2]  = '{1'b1, 6'd1,  8'h11, 8'hFF, 8'h00};
        tbl[3]  = '{1'b1, 6'd2,  8'h22, 8'hFF, 8'h00};
        tbl[4]  = '{1'b1, 6'd3,  8'h33, 8'hFF, 8'h00};
        tbl[5]  = '{1'b1, 6'd7,  8'h5A, 8'hFF, 8'h00};
        tbl[6]  = '{1'b1, 6'd7,  8'h00, 8'h00, 8'h00};
        tbl[7]  = '{1'b0, 6'd7,  8'h00, 8'h00, 8'h5A};
        tbl[8]  = '{1'b1, 6'd63, 8'hC3, 8'hFF, 8'h00};
        tbl[9]  = '{1'b0, 6'd63, 8'h00, 8'h00, 8'hC3};
        tbl[10] = '{1'b0, 6'd0,  8'h00, 8'h00, 8'h00};
        tbl[11] = '{1'b1, 6'd0,  8'hF0, 8'h3C, 8'h00};
        tbl[12] = '{1'b0, 6'd0,  8'h00, 8'h00, 8'h30};
        tbl[13] = '{1'b1, 6'd30, 8'h77, 8'hFF, 8'h00};

        // Reset: three posedges with RST high.
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK); #1;
        chk("rst_pins", 32'({sram_cen, sram_gwen, sram_wen, sram_a, sram_d}),
            32'({1'b1, 1'b1, 8'hFF, 6'd0, 8'h00}));
        chk("rst_outputs", 32'({req_ready, rsp_valid, rsp_rdata, init_done}), 32'd0);
        @(posedge CLK); #1;
        RST = 1'b0;
        init_seq();

        pin_en = 1'b1; a_known = 1'b0; d_known = 1'b0;

        // Write then read back with exact latency.
        send(1'b1, 6'd5, 8'hA5, 8'hFF, 1'b0, 8'h00);
        send(1'b0, 6'd5, 8'h00, 8'h00, 1'b1, 8'hA5);
        chk("lat_n0", 32'(rsp_valid), 32'd0);
        @(posedge CLK); #1;
        chk("lat_n1", 32'(rsp_valid), 32'd0);
        @(posedge CLK); #1;
        chk("lat_n2", 32'({rsp_valid, rsp_rdata}), 32'({1'b1, 8'hA5}));
        drain();

        for (int i = 0; i < 14; i++)
            send(tbl[i].write, tbl[i].addr, tbl[i].wdata, tbl[i].wmask, !tbl[i].write, tbl[i].exp_rd);
        drain();

        // Back-pressure: only two reads fit while the consumer stalls.
        rsp_ready = 1'b0;
        send(1'b0, 6'd1, 8'h00, 8'h00, 1'b1, 8'h11);
        send(1'b0, 6'd2, 8'h00, 8'h00, 1'b1, 8'h22);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 6'd3;
        for (int k = 0; k < 6; k++) begin
            chk("bp_ready_low", 32'(req_ready), 32'd0);
            @(posedge CLK); #1;
        end
        chk("bp_head", 32'({rsp_valid, rsp_rdata}), 32'({1'b1, 8'h11}));
        rsp_ready = 1'b1;
        send(1'b0, 6'd3, 8'h00, 8'h00, 1'b1, 8'h33);
        drain();

        // Random traffic against the reference model.
        bp_en = 1'b1;
        for (int k = 0; k < 400; k++) begin
            w = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, DEPTH - 1)) : AW'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0:       m = 8'h00;
                1:       m = 8'hFF;
                default: m = 8'($urandom);
            endcase
            send(w, a, 8'($urandom), m, 1'b0, 8'h00);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge CLK); #1;
            end
        end
        bp_en = 1'b0;
        drain();

        // Reset in the middle of the clear sequence.
        pin_en = 1'b0;
        RST = 1'b1;
        repeat (2) begin
            @(posedge CLK); #1;
        end
        RST = 1'b0;
        found = 0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge CLK); #1;
            if (!sram_cen && sram_a == 6'd19) found = 1;
        end
        chk("clear_reached_19", 32'(found), 32'd1);
        RST = 1'b1;
        @(negedge CLK); #1;
        chk("abort_pins", 32'({sram_cen, init_done, sram_a}), 32'({1'b1, 1'b0, 6'd0}));
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RST = 1'b0;
        init_seq();

        pin_en = 1'b1; a_known = 1'b0; d_known = 1'b0;
        send(1'b0, 6'd30, 8'h00, 8'h00, 1'b1, 8'h00);
        send(1'b0, 6'd5,  8'h00, 8'h00, 1'b1, 8'h00);
        drain();
        repeat (3) begin
            @(posedge CLK); #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
